// File: rtl/aux_pwm.sv
`default_nettype none
// ============================================================================
//  Module      : aux_pwm
//  Description : Microcontroller-bus register file (64 x MC_DATA_WIDTH) with
//                an embedded two-phase PWM generator. The bus strobes are
//                asynchronous to clock and are synchronized before use. Each
//                write or read fires once per strobe rising edge.
//
//  Ports
//    clock       in   system clock, everything on the rising edge
//    reset       in   synchronous, active-high reset
//    mc_ce       in   chip enable, active low (asynchronous)
//    mc_we       in   write strobe, active high (asynchronous)
//    mc_oe       in   read strobe, active high (asynchronous)
//    mc_add      in   register address
//    mc_din      in   write data
//    mc_dout     out  registered read data
//    mc_dout_oe  out  data-pad output enable (mc_oe & ~mc_ce, combinational)
//    pwm_out     out  registered PWM waveform
//
//  Registers
//    ADDR_ON     high-phase length in PWM ticks (one tick = 2 clocks)
//    ADDR_OFF    low-phase length in PWM ticks; writing it restarts the PWM
//    ADDR_STATUS read-only {zeros, phase, pwm_out}; writes are dropped
//    others      plain read/write storage
//
//  Build option
//    AUX_PWM_SYNC_EN  defined   : 2-flop strobe synchronizers
//                     undefined : 1 register stage per strobe
//
//  Revision    : 1.0  initial release
// ============================================================================
module aux_pwm #(
    parameter int unsigned MC_DATA_WIDTH = 16,
    parameter int unsigned MC_ADD_WIDTH  = 6,
    parameter int unsigned ADDR_ON       = 25,
    parameter int unsigned ADDR_OFF      = 26,
    parameter int unsigned ADDR_STATUS   = 27
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     mc_ce,
    input  logic                     mc_we,
    input  logic                     mc_oe,
    input  logic [MC_ADD_WIDTH-1:0]  mc_add,
    input  logic [MC_DATA_WIDTH-1:0] mc_din,
    output logic [MC_DATA_WIDTH-1:0] mc_dout,
    output logic                     mc_dout_oe,
    output logic                     pwm_out
);

    localparam int unsigned NUM_REGS = 2 ** MC_ADD_WIDTH;

    localparam logic [MC_ADD_WIDTH-1:0] c_addr_on     = ADDR_ON[MC_ADD_WIDTH-1:0];
    localparam logic [MC_ADD_WIDTH-1:0] c_addr_off    = ADDR_OFF[MC_ADD_WIDTH-1:0];
    localparam logic [MC_ADD_WIDTH-1:0] c_addr_status = ADDR_STATUS[MC_ADD_WIDTH-1:0];

    // Synchronizer bit order is {ce, we, oe}. Chip enable idles high
    // (deselected), so its flops come out of reset at 1.
    localparam logic [2:0] c_sync_rst = 3'b100;

    typedef enum logic {
        ST_LOW  = 1'b0,
        ST_HIGH = 1'b1
    } state_e;

    // ------------------------------------------------------------------------
    // Strobe synchronizers
    // ------------------------------------------------------------------------
    logic [2:0] sync_q;

`ifdef AUX_PWM_SYNC_EN
    logic [2:0] meta_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            meta_q <= c_sync_rst;
            sync_q <= c_sync_rst;
        end else begin
            meta_q <= {mc_ce, mc_we, mc_oe};
            sync_q <= meta_q;
        end
    end
`else
    always_ff @(posedge clock) begin
        if (reset) begin
            sync_q <= c_sync_rst;
        end else begin
            sync_q <= {mc_ce, mc_we, mc_oe};
        end
    end
`endif

    logic ce_s;
    logic we_s;
    logic oe_s;

    assign ce_s = sync_q[2];
    assign we_s = sync_q[1];
    assign oe_s = sync_q[0];

    // Delayed copies of the synchronized strobes for rising-edge detection,
    // so a strobe held high commits exactly once.
    logic we_prev_q;
    logic oe_prev_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            we_prev_q <= 1'b0;
            oe_prev_q <= 1'b0;
        end else begin
            we_prev_q <= we_s;
            oe_prev_q <= oe_s;
        end
    end

    logic we_rise;
    logic oe_rise;
    logic wr_fire;
    logic rd_fire;

    assign we_rise = we_s & ~we_prev_q;
    assign oe_rise = oe_s & ~oe_prev_q;
    assign wr_fire = we_rise & ~ce_s;
    // A write rising on the same cycle suppresses the read entirely.
    assign rd_fire = oe_rise & ~ce_s & ~we_rise;

    // ------------------------------------------------------------------------
    // Register file
    // ------------------------------------------------------------------------
    logic [MC_DATA_WIDTH-1:0] regs_q [NUM_REGS];

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_fire && (mc_add != c_addr_status)) begin
            regs_q[mc_add] <= mc_din;
        end
    end

    logic [MC_DATA_WIDTH-1:0] on_val;
    logic [MC_DATA_WIDTH-1:0] off_val;

    assign on_val  = regs_q[c_addr_on];
    assign off_val = regs_q[c_addr_off];

    // ------------------------------------------------------------------------
    // PWM generator
    // ------------------------------------------------------------------------
    state_e      state_q;
    state_e      state_d;
    logic [15:0] cnt_q;
    logic [15:0] cnt_d;
    logic        presc_q;
    logic        presc_d;
    logic        pwm_q;

    logic        tick;
    logic        restart;
    logic [31:0] cnt_inc;
    logic [31:0] on_ext;
    logic [31:0] off_ext;

    assign tick    = presc_q;
    assign restart = wr_fire && (mc_add == c_addr_off);
    // Comparisons run in 32 bits so cnt+1 can reach 2^16 without wrapping.
    assign cnt_inc = {16'd0, cnt_q} + 32'd1;
    assign on_ext  = 32'(on_val);
    assign off_ext = 32'(off_val);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        presc_d = ~presc_q;

        if (restart) begin
            // Restart wins over a tick landing on the same cycle.
            presc_d = 1'b0;
            cnt_d   = 16'd0;
            state_d = (on_val != '0) ? ST_HIGH : ST_LOW;
        end else if (tick) begin
            case (state_q)
                ST_HIGH: begin
                    if ((cnt_inc >= on_ext) && (off_val != '0)) begin
                        state_d = ST_LOW;
                        cnt_d   = 16'd0;
                    end else if (cnt_inc < on_ext) begin
                        cnt_d = cnt_inc[15:0];
                    end
                end
                ST_LOW: begin
                    if ((cnt_inc >= off_ext) && (on_val != '0)) begin
                        state_d = ST_HIGH;
                        cnt_d   = 16'd0;
                    end else if (cnt_inc < off_ext) begin
                        cnt_d = cnt_inc[15:0];
                    end
                end
                default: begin
                    state_d = ST_LOW;
                    cnt_d   = 16'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_LOW;
            cnt_q   <= 16'd0;
            presc_q <= 1'b0;
            pwm_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            presc_q <= presc_d;
            // Output register follows the phase one clock later.
            pwm_q   <= (state_q == ST_HIGH);
        end
    end

    // ------------------------------------------------------------------------
    // Read path
    // ------------------------------------------------------------------------
    logic [MC_DATA_WIDTH-1:0] status_val;
    logic [MC_DATA_WIDTH-1:0] rd_data;
    logic [MC_DATA_WIDTH-1:0] dout_q;

    assign status_val = {{(MC_DATA_WIDTH-2){1'b0}}, (state_q == ST_HIGH), pwm_q};
    assign rd_data    = (mc_add == c_addr_status) ? status_val : regs_q[mc_add];

    always_ff @(posedge clock) begin
        if (reset) begin
            dout_q <= '0;
        end else if (rd_fire) begin
            dout_q <= rd_data;
        end
    end

    assign mc_dout    = dout_q;
    assign mc_dout_oe = mc_oe & ~mc_ce;
    assign pwm_out    = pwm_q;

endmodule
`default_nettype wire

// File: tb/tb_aux_pwm.sv
`default_nettype none
// ============================================================================
//  Module      : tb_aux_pwm
//  Description : Self-checking bench for aux_pwm: register read/write table,
//                PWM waveform timing, degenerate ON/OFF values, status
//                register, strobe priority, chip-enable gating and reset.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_aux_pwm;

`ifdef AUX_PWM_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif

    logic        clock;
    logic        reset;
    logic        mc_ce;
    logic        mc_we;
    logic        mc_oe;
    logic [5:0]  mc_add;
    logic [15:0] mc_din;
    logic [15:0] mc_dout;
    logic        mc_dout_oe;
    logic        pwm_out;

    int n_cmp;
    int n_err;

    aux_pwm dut (
        .clock      (clock),
        .reset      (reset),
        .mc_ce      (mc_ce),
        .mc_we      (mc_we),
        .mc_oe      (mc_oe),
        .mc_add     (mc_add),
        .mc_din     (mc_din),
        .mc_dout    (mc_dout),
        .mc_dout_oe (mc_dout_oe),
        .pwm_out    (pwm_out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [5:0]  addr;
        logic [15:0] data;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%04h, expected 0x%04h", name, act, exp);
        end
    endtask

    // Returns 1 ns after the commit edge with the strobe already released.
    task automatic do_write(input logic [5:0] a, input logic [15:0] d);
        repeat (LAT + 1) @(posedge clock);
        @(negedge clock);
        mc_ce  = 1'b0;
        mc_add = a;
        mc_din = d;
        mc_we  = 1'b1;
        repeat (LAT) @(posedge clock);
        #1;
        mc_we = 1'b0;
        mc_ce = 1'b1;
    endtask

    task automatic do_read(input logic [5:0] a, output logic [15:0] early, output logic [15:0] val);
        repeat (LAT + 1) @(posedge clock);
        @(negedge clock);
        mc_ce  = 1'b0;
        mc_add = a;
        mc_oe  = 1'b1;
        repeat (LAT - 1) @(posedge clock);
        #1 early = mc_dout;
        @(posedge clock);
        #1 val = mc_dout;
        mc_oe = 1'b0;
        mc_ce = 1'b1;
    endtask

    logic [15:0] early_v;
    logic [15:0] rd_v;

    initial begin
        n_cmp  = 0;
        n_err  = 0;
        reset  = 1'b1;
        mc_ce  = 1'b1;
        mc_we  = 1'b0;
        mc_oe  = 1'b0;
        mc_add = '0;
        mc_din = '0;

        vecs[0] = '{6'd0,  16'h0001, 16'h0001};
        vecs[1] = '{6'd63, 16'hFFFF, 16'hFFFF};
        vecs[2] = '{6'd10, 16'hAAAA, 16'h5555};
        vecs[3] = '{6'd10, 16'h5555, 16'h5555};
        vecs[4] = '{6'd1,  16'h8000, 16'h8000};
        vecs[5] = '{6'd24, 16'hC3A5, 16'hC3A5};
        vecs[6] = '{6'd28, 16'h0F0F, 16'h0F0F};

        // ---------------- reset state ----------------
        repeat (3) @(posedge clock);
        #1;
        check("reset_dout", mc_dout, 16'h0000);
        check("reset_pwm", {15'd0, pwm_out}, 16'h0000);
        check("reset_dout_oe", {15'd0, mc_dout_oe}, 16'h0000);
        @(negedge clock);
        reset = 1'b0;

        // ---------------- basic write/read ----------------
        do_write(6'd5, 16'h1234);
        do_read(6'd5, early_v, rd_v);
        check("read5_before_edge", early_v, 16'h0000);
        check("read5", rd_v, 16'h1234);

        // ---------------- table-driven write/read ----------------
        for (int i = 0; i < 7; i++) do_write(vecs[i].addr, vecs[i].data);
        for (int i = 0; i < 7; i++) begin
            do_read(vecs[i].addr, early_v, rd_v);
            check($sformatf("table_rd[%0d]", i), rd_v, vecs[i].exp);
        end

        // ---------------- simultaneous strobes -> write only ----------------
        do_read(6'd5, early_v, rd_v);
        check("reread5", rd_v, 16'h1234);
        repeat (LAT + 1) @(posedge clock);
        @(negedge clock);
        mc_ce = 1'b0; mc_add = 6'd7; mc_din = 16'hBEEF; mc_we = 1'b1; mc_oe = 1'b1;
        repeat (LAT + 2) @(posedge clock);
        #1;
        check("simul_no_read", mc_dout, 16'h1234);
        mc_we = 1'b0; mc_oe = 1'b0; mc_ce = 1'b1;
        do_read(6'd7, early_v, rd_v);
        check("simul_wrote", rd_v, 16'hBEEF);

        // ---------------- chip enable gating ----------------
        @(negedge clock);
        mc_ce = 1'b0; mc_oe = 1'b1;
        #1 check("dout_oe_sel", {15'd0, mc_dout_oe}, 16'h0001);
        mc_oe = 1'b0; mc_ce = 1'b1;
        repeat (LAT + 1) @(posedge clock);
        @(negedge clock);
        mc_ce = 1'b1; mc_add = 6'd7; mc_din = 16'h0001; mc_we = 1'b1; mc_oe = 1'b1;
        #1 check("dout_oe_desel", {15'd0, mc_dout_oe}, 16'h0000);
        repeat (LAT + 2) @(posedge clock);
        #1;
        check("ce_no_read", mc_dout, 16'hBEEF);
        mc_we = 1'b0; mc_oe = 1'b0;
        do_read(6'd7, early_v, rd_v);
        check("ce_no_write", rd_v, 16'hBEEF);

        // ---------------- PWM ON=3 OFF=2 ----------------
        do_write(6'd25, 16'd3);
        do_write(6'd26, 16'd2);
        for (int k = 1; k <= 20; k++) begin
            @(posedge clock);
            #1 check($sformatf("pwm32_k%0d", k), {15'd0, pwm_out},
                     (((k - 1) % 10) < 6) ? 16'h0001 : 16'h0000);
        end

        // ---------------- ON=0 OFF=5 -> constant low ----------------
        do_write(6'd25, 16'd0);
        do_write(6'd26, 16'd5);
        for (int k = 1; k <= 24; k++) begin
            @(posedge clock);
            #1 check($sformatf("pwm_on0_k%0d", k), {15'd0, pwm_out}, 16'h0000);
        end
        do_read(6'd27, early_v, rd_v);
        check("status_low", rd_v, 16'h0000);

        // ---------------- ON=4 OFF=0 -> constant high ----------------
        do_write(6'd25, 16'd4);
        do_write(6'd26, 16'd0);
        for (int k = 1; k <= 30; k++) begin
            @(posedge clock);
            #1 check($sformatf("pwm_off0_k%0d", k), {15'd0, pwm_out}, 16'h0001);
        end

        // ---------------- status register ----------------
        do_write(6'd27, 16'hFFFF);
        do_read(6'd27, early_v, rd_v);
        check("status_high", rd_v, 16'h0003);
        check("status_bit0_pwm", {15'd0, rd_v[0]}, 16'h0001);

        // ---------------- reset mid-PWM ----------------
        do_write(6'd25, 16'd8);
        do_write(6'd26, 16'd8);
        repeat (5) @(posedge clock);
        #1 check("pwm88_high", {15'd0, pwm_out}, 16'h0001);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        check("rst_pwm", {15'd0, pwm_out}, 16'h0000);
        check("rst_dout", mc_dout, 16'h0000);
        @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < 64; i++) begin
            do_read(i[5:0], early_v, rd_v);
            check($sformatf("rst_reg[%0d]", i), rd_v, 16'h0000);
        end
        repeat (20) @(posedge clock);
        #1 check("rst_pwm_stays", {15'd0, pwm_out}, 16'h0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Overall time bound so a stuck run still ends.
    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, got running, expected done");
        n_err++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/aux_pwm.md
AUX_PWM -- requirements
Module: aux_pwm

Interface
REQ-001 SHALL have parameter MC_DATA_WIDTH, default 16, the register and data bus width.
REQ-002 SHALL have parameter MC_ADD_WIDTH, default 6, the address width (64 registers).
REQ-003 SHALL have parameter ADDR_ON, default 25 (0x19), the PWM high-phase length register.
REQ-004 SHALL have parameter ADDR_OFF, default 26 (0x1A), the PWM low-phase length register.
REQ-005 SHALL have parameter ADDR_STATUS, default 27 (0x1B), the read-only status register.
REQ-006 SHALL have port clock, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-007 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-008 SHALL have port mc_ce, input, 1 bit: chip enable, active low, asynchronous to clock.
REQ-009 SHALL have port mc_we, input, 1 bit: write strobe, active high, asynchronous.
REQ-010 SHALL have port mc_oe, input, 1 bit: read strobe, active high, asynchronous.
REQ-011 SHALL have port mc_add, input, MC_ADD_WIDTH bits: the register address.
REQ-012 SHALL have port mc_din, input, MC_DATA_WIDTH bits: write data.
REQ-013 SHALL have port mc_dout, output, MC_DATA_WIDTH bits: registered read data.
REQ-014 SHALL have port mc_dout_oe, output, 1 bit: data-pad output enable, combinationally equal to mc_oe AND NOT mc_ce.
REQ-015 SHALL have port pwm_out, output, 1 bit: the registered PWM waveform.

Function
REQ-016 SHALL pass mc_ce, mc_we and mc_oe each through a 2-flop synchronizer, giving ce_s, we_s and oe_s.
REQ-017 SHALL perform a write on the cycle after we_s rises while ce_s=0: register[mc_add] <= mc_din, once per strobe.
- This is 3 clock edges after the mc_we pin rises.
REQ-018 SHALL perform a read on the cycle after oe_s rises while ce_s=0: mc_dout <= register[mc_add].
- If ADDR_STATUS, mc_dout <= {zeros, phase, pwm_out}.
REQ-019 SHALL ignore writes to ADDR_STATUS.
REQ-020 SHALL treat all other addresses as plain read/write storage.
REQ-021 SHALL give priority to the write when we_s and oe_s rise on the same cycle; no read occurs.
REQ-022 SHALL run a 1-bit prescaler that toggles every clock; a PWM tick is the cycle where the prescaler equals 1 (clock/2).
REQ-023 SHALL implement the PWM as states HIGH and LOW with a 16-bit phase counter cnt; pwm_out=1 only in HIGH; phase=1 in HIGH.
REQ-024 SHALL, on a tick in HIGH:
- if cnt+1 >= ON and OFF != 0, go to LOW with cnt=0;
- otherwise, if cnt+1 < ON, increment cnt.
REQ-025 SHALL, on a tick in LOW:
- if cnt+1 >= OFF and ON != 0, go to HIGH with cnt=0;
- otherwise, if cnt+1 < OFF, increment cnt.
REQ-026 SHALL give ON=0 a constant low output and OFF=0 with ON!=0 a constant high output; the period is 2*(ON+OFF) clocks.
REQ-027 SHALL compare against live register values, so ON/OFF changes take effect at the next comparison; cnt never wraps.
REQ-028 SHALL treat a committed write to ADDR_OFF as a restart.
- Next edge: prescaler=0, cnt=0.
- State becomes HIGH if ON!=0, else LOW.
- The restart overrides a tick on the same cycle.

Reset
REQ-029 SHALL, on reset, clear all registers to 0, mc_dout=0, pwm_out=0, state=LOW, cnt=0, prescaler=0, and all synchronizer flops to 0 except mc_ce flops to 1.
REQ-030 SHALL make reset take priority over writes, reads and ticks; a reset mid-transaction discards that transaction.

Configuration
REQ-031 SHALL support macro AUX_PWM_SYNC_EN.
- Defined: 2-flop synchronizers per REQ-016; write latency 3 edges.
- Undefined: ce_s/we_s/oe_s are 1 register stage; write latency 2 edges; all else identical.

Verification
REQ-032 SHALL cover register write/read: write 0x1234 to address 5, then read address 5 -> mc_dout=0x1234 on the edge after oe_s rises.
REQ-033 SHALL cover PWM timing: ON=3, then OFF=2 (the restart) -> pwm_out high 6 clocks, low 4 clocks, repeating, first high 1 clock after the commit.
REQ-034 SHALL cover edge cases:
- ON=0, OFF=5 -> pwm_out stays 0;
- ON=4, OFF=0 -> pwm_out stays 1 after the restart.
REQ-035 SHALL cover status: write to ADDR_STATUS 0xFFFF, then read it -> upper bits 0, bit0 equals pwm_out.
REQ-036 SHALL cover simultaneous strobes and CE: we and oe rising together -> write only; with mc_ce=1 -> no register change, mc_dout_oe=0.
REQ-037 SHALL cover reset: assert reset mid-PWM with ON=OFF=8 -> pwm_out=0 next edge, all registers read 0.
